// File: rtl/mc_alu_if.sv
// Handshake and operand/result bundle between the EX-stage control FSM and mc_alu.
interface mc_alu_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               start;
  logic [3:0]         ALU_Control;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               overflow;

  modport master (
    output start, ALU_Control, a, b, shamt,
    input  busy, done, result, zero, overflow
  );

  modport slave (
    input  start, ALU_Control, a, b, shamt,
    output busy, done, result, zero, overflow
  );
endinterface

// File: rtl/mc_alu.sv
// Multi-cycle EX-stage ALU: single-cycle arith/logic, bit-serial shifts,
// start/busy/done handshake with registered result, zero and overflow flags.
module mc_alu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic      clk,
  input  logic      reset,
  mc_alu_if.slave   bus
);

  localparam int unsigned HALF = WIDTH / 2;

  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0010;
  localparam logic [3:0] OP_SRA  = 4'b0011;
  localparam logic [3:0] OP_SLLV = 4'b0100;
  localparam logic [3:0] OP_SRLV = 4'b0101;
  localparam logic [3:0] OP_SRAV = 4'b0110;
  localparam logic [3:0] OP_LUI  = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1010;
  localparam logic [3:0] OP_OR   = 4'b1011;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_NOR  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b1110;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_e;

  state_e             state_q, state_d;
  shkind_e            kind_q, kind_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   sum, diff, alu_res, fin_res, work_step;
  logic               alu_ovf, is_shift;
  shkind_e            kind_c;
  logic [SHAMT_W-1:0] k_c;

  // Single-cycle datapath and shift decode from the live inputs
  always_comb begin
    sum      = bus.a + bus.b;
    diff     = bus.a - bus.b;
    alu_res  = '0;
    alu_ovf  = 1'b0;
    is_shift = 1'b0;
    kind_c   = SH_LL;
    k_c      = bus.a[SHAMT_W-1:0];
    case (bus.ALU_Control)
      OP_SLL:  begin is_shift = 1'b1; kind_c = SH_LL; k_c = bus.shamt; end
      OP_SRL:  begin is_shift = 1'b1; kind_c = SH_RL; k_c = bus.shamt; end
      OP_SRA:  begin is_shift = 1'b1; kind_c = SH_RA; k_c = bus.shamt; end
      OP_SLLV: begin is_shift = 1'b1; kind_c = SH_LL; end
      OP_SRLV: begin is_shift = 1'b1; kind_c = SH_RL; end
      OP_SRAV: begin is_shift = 1'b1; kind_c = SH_RA; end
      OP_LUI:  alu_res = {bus.b[HALF-1:0], {HALF{1'b0}}};
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_SLT:  alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_SLTU: alu_res = WIDTH'(bus.a < bus.b);
      default: alu_res = '0;
    endcase
    // A zero-amount shift completes immediately with the unshifted operand
    fin_res = is_shift ? bus.b : alu_res;
  end

  // One-bit shift step of the serial shifter
  always_comb begin
    case (kind_q)
      SH_LL:   work_step = {work_q[WIDTH-2:0], 1'b0};
      SH_RL:   work_step = {1'b0, work_q[WIDTH-1:1]};
      default: work_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    work_d   = work_q;
    count_d  = count_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_shift && (k_c != '0)) begin
            work_d  = bus.b;
            count_d = k_c;
            kind_d  = kind_c;
            state_d = SHIFT;
          end else begin
            result_d = fin_res;
            zero_d   = (fin_res == '0);
            ovf_d    = is_shift ? 1'b0 : alu_ovf;
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        work_d  = work_step;
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          result_d = work_step;
          zero_d   = (work_step == '0);
          ovf_d    = 1'b0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      kind_q   <= SH_LL;
      work_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      work_q   <= work_d;
      count_q  <= count_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_mc_alu.sv
// Self-checking bench for mc_alu: directed vector table, hand-written corner
// sequences and randomized ops against an arithmetic reference model.
module tb_mc_alu;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] prev_res;

  mc_alu_if #(.WIDTH(32), .SHAMT_W(5)) bus ();
  mc_alu #(.WIDTH(32), .SHAMT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  // Reference model from the operation definitions using plain arithmetic
  task automatic ref_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, output logic [31:0] r, output logic o, output int lat);
    int     k;
    longint sa, sb, s;
    k  = (c >= 4'd1 && c <= 4'd3) ? int'(sh) : int'(a % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 32'h0;
    o  = 1'b0;
    lat = 1;
    case (c)
      4'd1, 4'd4: r = b << k;
      4'd2, 4'd5: r = b >> k;
      4'd3, 4'd6: r = $unsigned($signed(b) >>> k);
      4'd7:  r = 32'((longint'(b) % 65536) * 65536);
      4'd8:  begin s = sa + sb; r = a + b; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd9:  begin s = sa - sb; r = a - b; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd10: r = a & b;
      4'd11: r = a | b;
      4'd12: r = a ^ b;
      4'd13: r = ~(a | b);
      4'd14: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd15: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'h0;
    endcase
    if (c >= 4'd1 && c <= 4'd6 && k > 0) lat = k + 1;
  endtask

  // Issue one op from an idle DUT (called at posedge+1) and check its completion
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] er, input logic eo, input int el);
    int cycles;
    int busy_cnt;
    bus.start = 1'b1;
    bus.ALU_Control = c;
    bus.a = a;
    bus.b = b;
    bus.shamt = sh;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.ALU_Control = 4'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
    bus.shamt = 5'($urandom);
    cycles = 1;
    busy_cnt = 0;
    if (el > 1) chk(tag, "result_hold", bus.result, prev_res);
    while (!bus.done && cycles < 40) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      cycles++;
    end
    if (bus.busy) busy_cnt++;
    chk(tag, "done_seen", 32'(bus.done), 32'd1);
    chk(tag, "latency", 32'(cycles), 32'(el));
    chk(tag, "busy_cycles", 32'(busy_cnt), 32'(el));
    chk(tag, "result", bus.result, er);
    chk(tag, "zero", 32'(bus.zero), 32'(er == 32'h0));
    chk(tag, "overflow", 32'(bus.overflow), 32'(eo));
    @(posedge clk); #1;
    chk(tag, "done_pulse_end", 32'(bus.done), 32'd0);
    chk(tag, "idle_after", 32'(bus.busy), 32'd0);
    prev_res = er;
  endtask

  initial begin
    int          dn;
    int          cycles;
    logic [3:0]  c;
    logic [31:0] ra, rb, er;
    logic [4:0]  rs;
    logic        eo;
    int          el;

    vecs[0]  = '{4'b1000, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1, 1};
    vecs[1]  = '{4'b1001, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0, 1};
    vecs[2]  = '{4'b1110, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1};
    vecs[3]  = '{4'b1111, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0, 1};
    vecs[4]  = '{4'b0011, 32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 5};
    vecs[5]  = '{4'b0101, 32'h0000001F, 32'h80000000, 5'd0,  32'h00000001, 1'b0, 32};
    vecs[6]  = '{4'b0100, 32'h00000020, 32'h00001234, 5'd7,  32'h00001234, 1'b0, 1};
    vecs[7]  = '{4'b0111, 32'h12345678, 32'h0000ABCD, 5'd0,  32'hABCD0000, 1'b0, 1};
    vecs[8]  = '{4'b1001, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1, 1};
    vecs[9]  = '{4'b0000, 32'hDEADBEEF, 32'hCAFEF00D, 5'd3,  32'h00000000, 1'b0, 1};
    vecs[10] = '{4'b1101, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 1};
    vecs[11] = '{4'b0001, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 32};
    vecs[12] = '{4'b1100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0, 1};
    vecs[13] = '{4'b0110, 32'h00000008, 32'h70000000, 5'd0,  32'h00700000, 1'b0, 9};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.ALU_Control = 4'h0;
    bus.a = 32'h0;
    bus.b = 32'h0;
    bus.shamt = 5'h0;
    prev_res = 32'h0;
    #12;
    chk("reset", "busy", 32'(bus.busy), 32'd0);
    chk("reset", "done", 32'(bus.done), 32'd0);
    chk("reset", "result", bus.result, 32'h0);
    chk("reset", "zero", 32'(bus.zero), 32'd1);
    chk("reset", "overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].sh,
             vecs[i].res, vecs[i].ovf, vecs[i].lat);

    // Asynchronous reset in the middle of a shift
    bus.start = 1'b1;
    bus.ALU_Control = 4'b0001;
    bus.a = 32'h0;
    bus.b = 32'h00000001;
    bus.shamt = 5'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid", "busy_before", 32'(bus.busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid", "busy", 32'(bus.busy), 32'd0);
    chk("rst_mid", "result", bus.result, 32'h0);
    chk("rst_mid", "zero", 32'(bus.zero), 32'd1);
    chk("rst_mid", "done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    chk("rst_mid", "no_done", 32'(dn), 32'd0);
    chk("rst_mid", "result_after", bus.result, 32'h0);
    prev_res = 32'h0;

    // start held high through a 3-cycle sll, then back-to-back add
    bus.start = 1'b1;
    bus.ALU_Control = 4'b0001;
    bus.a = 32'h0;
    bus.b = 32'h00000003;
    bus.shamt = 5'd2;
    @(posedge clk); #1;
    cycles = 1;
    while (!bus.done && cycles < 10) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("hold", "latency", 32'(cycles), 32'd3);
    chk("hold", "result", bus.result, 32'h0000000C);
    bus.ALU_Control = 4'b1000;
    bus.a = 32'h2;
    bus.b = 32'h3;
    @(posedge clk); #1;
    chk("hold", "done_once", 32'(bus.done), 32'd0);
    chk("hold", "idle_gap", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("hold", "next_done", 32'(bus.done), 32'd1);
    chk("hold", "next_result", bus.result, 32'h5);
    @(posedge clk); #1;
    chk("hold", "next_done_end", 32'(bus.done), 32'd0);
    prev_res = 32'h5;

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      c  = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      rs = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) ra = ra & 32'hFFFFFFE0;
      if ($urandom_range(0, 3) == 0) rs = 5'd0;
      ref_model(c, ra, rb, rs, er, eo, el);
      run_op($sformatf("rnd%0d", i), c, ra, rb, rs, er, eo, el);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
